// File: rtl/addr_patch_unit.sv
// addr_patch_unit
//
// Address patch stage between a slave-side request port and a master-side
// request port. A table of NUM_PATCH match/replace entries is checked against
// every accepted address; the lowest-index enabled entry whose match address
// equals the request replaces it, otherwise the address passes through. The
// result is held in one registered output stage with a valid/ready handshake.
// Entries may be one-shot (self-disable after their first hit). A saturating
// counter tallies accepted hits.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   si_valid_i/si_ready_o  request handshake, si_addr_i request address
//   mi_valid_o/mi_ready_i  output handshake
//   mi_addr_o              forwarded (possibly patched) address
//   mi_patched_o           1 = mi_addr_o came from a table entry
//   mi_idx_o               index of the hitting entry (0 when not patched)
//   ctl_we_i, ctl_idx_i    table write strobe and target entry
//   ctl_en_i, ctl_oneshot_i, ctl_pat_addr_i, ctl_pat_data_i  entry contents
//   ctl_cnt_clr_i          synchronous clear of hit_cnt_o
//   hit_cnt_o              saturating count of accepted hits
module addr_patch_unit #(
  parameter int ADDR_W    = 32,
  parameter int NUM_PATCH = 4,
  parameter int IDX_W     = (NUM_PATCH > 1) ? $clog2(NUM_PATCH) : 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              si_valid_i,
  output logic              si_ready_o,
  input  logic [ADDR_W-1:0] si_addr_i,
  output logic              mi_valid_o,
  input  logic              mi_ready_i,
  output logic [ADDR_W-1:0] mi_addr_o,
  output logic              mi_patched_o,
  output logic [IDX_W-1:0]  mi_idx_o,
  input  logic              ctl_we_i,
  input  logic [IDX_W-1:0]  ctl_idx_i,
  input  logic              ctl_en_i,
  input  logic              ctl_oneshot_i,
  input  logic [ADDR_W-1:0] ctl_pat_addr_i,
  input  logic [ADDR_W-1:0] ctl_pat_data_i,
  input  logic              ctl_cnt_clr_i,
  output logic [CNT_W-1:0]  hit_cnt_o
);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              en_q       [NUM_PATCH];
  logic              oneshot_q  [NUM_PATCH];
  logic [ADDR_W-1:0] pat_addr_q [NUM_PATCH];
  logic [ADDR_W-1:0] pat_data_q [NUM_PATCH];

  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              patched_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [ADDR_W-1:0] hit_data;

  assign si_ready_o = !vld_p0 || mi_ready_i;
  assign accept     = si_valid_i && si_ready_o;

  // Priority lookup against the current (pre-write) table contents; the
  // first hit found scanning upward from entry 0 wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_data = '0;
    for (int i = 0; i < NUM_PATCH; i++) begin
      if (!hit && en_q[i] && (pat_addr_q[i] == si_addr_i)) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(i);
        hit_data = pat_data_q[i];
      end
    end
  end

  // Table: a software write to an entry takes precedence over that entry's
  // own one-shot self-disable in the same cycle. Out-of-range indices match
  // no entry and are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_PATCH; i++) begin
        en_q[i]       <= 1'b0;
        oneshot_q[i]  <= 1'b0;
        pat_addr_q[i] <= '0;
        pat_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PATCH; i++) begin
        if (ctl_we_i && (ctl_idx_i == IDX_W'(i))) begin
          en_q[i]       <= ctl_en_i;
          oneshot_q[i]  <= ctl_oneshot_i;
          pat_addr_q[i] <= ctl_pat_addr_i;
          pat_data_q[i] <= ctl_pat_data_i;
        end else if (accept && hit && (hit_idx == IDX_W'(i)) && oneshot_q[i]) begin
          en_q[i] <= 1'b0;
        end
      end
    end
  end

  // ---- stage p0: registered output of the lookup ----
  // Payload loads only on accept and otherwise holds, so it stays stable
  // while the downstream stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p0     <= 1'b0;
      addr_p0    <= '0;
      patched_p0 <= 1'b0;
      idx_p0     <= '0;
    end else if (accept) begin
      vld_p0     <= 1'b1;
      addr_p0    <= hit ? hit_data : si_addr_i;
      patched_p0 <= hit;
      idx_p0     <= hit ? hit_idx : '0;
    end else if (mi_ready_i) begin
      vld_p0 <= 1'b0;
    end
  end

  // Hit counter; clear beats a coincident hit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (ctl_cnt_clr_i) begin
      cnt_q <= '0;
    end else if (accept && hit) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign mi_valid_o   = vld_p0;
  assign mi_addr_o    = addr_p0;
  assign mi_patched_o = patched_p0;
  assign mi_idx_o     = idx_p0;
  assign hit_cnt_o    = cnt_q;

endmodule

// File: tb/tb_addr_patch_unit.sv
// Testbench for addr_patch_unit: a directed vector table, hand-written
// backpressure and reset sequences, then randomized traffic against a
// behavioural model. A second instance with a 2-bit counter shares the
// stimulus to exercise saturation.
module tb_addr_patch_unit;

  localparam int NP = 4;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic        r;
    logic        we;
    logic [1:0]  idx;
    logic        en;
    logic        os;
    logic [31:0] pa;
    logic [31:0] pd;
    logic        clr;
    logic        ev;
    logic [31:0] ea;
    logic        ep;
    logic [1:0]  ei;
    logic [15:0] ec;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        si_valid_i = 1'b0;
  logic [31:0] si_addr_i = '0;
  logic        mi_ready_i = 1'b0;
  logic        ctl_we_i = 1'b0;
  logic [1:0]  ctl_idx_i = '0;
  logic        ctl_en_i = 1'b0;
  logic        ctl_oneshot_i = 1'b0;
  logic [31:0] ctl_pat_addr_i = '0;
  logic [31:0] ctl_pat_data_i = '0;
  logic        ctl_cnt_clr_i = 1'b0;

  logic        si_ready_o, mi_valid_o, mi_patched_o;
  logic [31:0] mi_addr_o;
  logic [1:0]  mi_idx_o;
  logic [15:0] hit_cnt_o;
  logic        si_ready_s, mi_valid_s, mi_patched_s;
  logic [31:0] mi_addr_s;
  logic [1:0]  mi_idx_s;
  logic [1:0]  hit_cnt_s;

  always #5 clk = ~clk;

  addr_patch_unit #(.ADDR_W(32), .NUM_PATCH(NP), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .si_valid_i(si_valid_i), .si_ready_o(si_ready_o), .si_addr_i(si_addr_i),
    .mi_valid_o(mi_valid_o), .mi_ready_i(mi_ready_i), .mi_addr_o(mi_addr_o),
    .mi_patched_o(mi_patched_o), .mi_idx_o(mi_idx_o),
    .ctl_we_i(ctl_we_i), .ctl_idx_i(ctl_idx_i), .ctl_en_i(ctl_en_i),
    .ctl_oneshot_i(ctl_oneshot_i), .ctl_pat_addr_i(ctl_pat_addr_i),
    .ctl_pat_data_i(ctl_pat_data_i), .ctl_cnt_clr_i(ctl_cnt_clr_i),
    .hit_cnt_o(hit_cnt_o)
  );

  addr_patch_unit #(.ADDR_W(32), .NUM_PATCH(NP), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_ni(rst_ni),
    .si_valid_i(si_valid_i), .si_ready_o(si_ready_s), .si_addr_i(si_addr_i),
    .mi_valid_o(mi_valid_s), .mi_ready_i(mi_ready_i), .mi_addr_o(mi_addr_s),
    .mi_patched_o(mi_patched_s), .mi_idx_o(mi_idx_s),
    .ctl_we_i(ctl_we_i), .ctl_idx_i(ctl_idx_i), .ctl_en_i(ctl_en_i),
    .ctl_oneshot_i(ctl_oneshot_i), .ctl_pat_addr_i(ctl_pat_addr_i),
    .ctl_pat_data_i(ctl_pat_data_i), .ctl_cnt_clr_i(ctl_cnt_clr_i),
    .hit_cnt_o(hit_cnt_s)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: table as arrays, hit total since last clear as an
  // unbounded integer; a saturating counter equals min(total, max).
  logic        m_en [NP];
  logic        m_os [NP];
  logic [31:0] m_pa [NP];
  logic [31:0] m_pd [NP];
  logic        m_vld;
  logic [31:0] m_addr;
  logic        m_pat;
  logic [1:0]  m_idx;
  int          m_hits;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_en[i] = 1'b0; m_os[i] = 1'b0; m_pa[i] = '0; m_pd[i] = '0;
    end
    m_vld = 1'b0; m_addr = '0; m_pat = 1'b0; m_idx = '0; m_hits = 0;
  endtask

  function automatic logic [63:0] sat(input int n, input int maxv);
    return (n > maxv) ? 64'(maxv) : 64'(n);
  endfunction

  // One clock cycle: drive at the falling edge, check ready combinationally,
  // advance the model, then compare registered outputs at the next falling edge.
  task automatic step(input vec_t s);
    logic rdy, acc, h;
    int hi;
    si_valid_i = s.v; si_addr_i = s.a; mi_ready_i = s.r;
    ctl_we_i = s.we; ctl_idx_i = s.idx; ctl_en_i = s.en; ctl_oneshot_i = s.os;
    ctl_pat_addr_i = s.pa; ctl_pat_data_i = s.pd; ctl_cnt_clr_i = s.clr;
    #1;
    rdy = !m_vld || s.r;
    acc = s.v && rdy;
    chk("si_ready", 64'(si_ready_o), 64'(rdy));
    h = 1'b0; hi = 0;
    for (int i = 0; i < NP; i++)
      if (!h && m_en[i] && m_pa[i] == s.a) begin h = 1'b1; hi = i; end
    if (acc) begin
      m_vld = 1'b1;
      m_pat = h;
      m_addr = h ? m_pd[hi] : s.a;
      m_idx = h ? 2'(hi) : 2'd0;
      if (h) begin
        m_hits++;
        if (m_os[hi]) m_en[hi] = 1'b0;
      end
    end else if (s.r) begin
      m_vld = 1'b0;
    end
    if (s.clr) m_hits = 0;
    if (s.we) begin
      m_en[s.idx] = s.en; m_os[s.idx] = s.os; m_pa[s.idx] = s.pa; m_pd[s.idx] = s.pd;
    end
    @(negedge clk);
    chk("mi_valid", 64'(mi_valid_o), 64'(m_vld));
    chk("mi_addr", 64'(mi_addr_o), 64'(m_addr));
    chk("mi_patched", 64'(mi_patched_o), 64'(m_pat));
    chk("mi_idx", 64'(mi_idx_o), 64'(m_idx));
    chk("hit_cnt16", 64'(hit_cnt_o), sat(m_hits, 65535));
    chk("hit_cnt2", 64'(hit_cnt_s), sat(m_hits, 3));
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] a, input logic we,
                              input logic [1:0] idx, input logic en, input logic os,
                              input logic [31:0] pa, input logic [31:0] pd,
                              input logic clr, input logic ev, input logic [31:0] ea,
                              input logic ep, input logic [1:0] ei, input logic [15:0] ec);
    vec_t t;
    t.v = v; t.a = a; t.r = 1'b1; t.we = we; t.idx = idx; t.en = en; t.os = os;
    t.pa = pa; t.pd = pd; t.clr = clr;
    t.ev = ev; t.ea = ea; t.ep = ep; t.ei = ei; t.ec = ec;
    return t;
  endfunction

  vec_t tbl[$];
  vec_t s;
  logic [31:0] held;

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(mi_valid_o), 64'd0);
    chk("rst_addr", 64'(mi_addr_o), 64'd0);
    chk("rst_patched", 64'(mi_patched_o), 64'd0);
    chk("rst_idx", 64'(mi_idx_o), 64'd0);
    chk("rst_cnt", 64'(hit_cnt_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    //          v  addr     we idx en os pat      data    clr | ev ea       ep ei cnt
    tbl.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0,          1, 32'h1000, 0, 0, 0));
    tbl.push_back(mk(1, 32'h2000, 0, 0, 0, 0, 0, 0, 0,          1, 32'h2000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h4000, 32'h8000, 0,   0, 32'h2000, 0, 0, 0));
    tbl.push_back(mk(1, 32'h4000, 0, 0, 0, 0, 0, 0, 0,          1, 32'h8000, 1, 1, 1));
    tbl.push_back(mk(1, 32'h4000, 0, 0, 0, 0, 0, 0, 0,          1, 32'h8000, 1, 1, 2));
    tbl.push_back(mk(1, 32'h4000, 0, 0, 0, 0, 0, 0, 0,          1, 32'h8000, 1, 1, 3));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 32'h4000, 32'hA000, 0,   0, 32'h8000, 1, 1, 3));
    tbl.push_back(mk(0, 0, 1, 2, 1, 0, 32'h4000, 32'hB000, 0,   0, 32'h8000, 1, 1, 3));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 32'h4000, 32'h8000, 0,   0, 32'h8000, 1, 1, 3));
    tbl.push_back(mk(1, 32'h4000, 0, 0, 0, 0, 0, 0, 0,          1, 32'hA000, 1, 0, 4));
    tbl.push_back(mk(1, 32'h4000, 0, 0, 0, 0, 0, 0, 0,          1, 32'hB000, 1, 2, 5));
    tbl.push_back(mk(1, 32'h5000, 1, 3, 1, 0, 32'h5000, 32'hC000, 0, 1, 32'h5000, 0, 0, 5));
    tbl.push_back(mk(1, 32'h5000, 0, 0, 0, 0, 0, 0, 0,          1, 32'hC000, 1, 3, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 32'hC000, 1, 3, 6));
    tbl.push_back(mk(1, 32'h4000, 0, 0, 0, 0, 0, 0, 1,          1, 32'hB000, 1, 2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 32'h6000, 32'hD000, 0,   0, 32'hB000, 1, 2, 0));
    tbl.push_back(mk(1, 32'h6000, 1, 0, 1, 1, 32'h6000, 32'hE000, 0, 1, 32'hD000, 1, 0, 1));
    tbl.push_back(mk(1, 32'h6000, 0, 0, 0, 0, 0, 0, 0,          1, 32'hE000, 1, 0, 2));
    tbl.push_back(mk(1, 32'h6000, 0, 0, 0, 0, 0, 0, 0,          1, 32'h6000, 0, 0, 2));

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k]);
      chk($sformatf("vec%0d_valid", k), 64'(mi_valid_o), 64'(tbl[k].ev));
      chk($sformatf("vec%0d_addr", k), 64'(mi_addr_o), 64'(tbl[k].ea));
      chk($sformatf("vec%0d_patched", k), 64'(mi_patched_o), 64'(tbl[k].ep));
      chk($sformatf("vec%0d_idx", k), 64'(mi_idx_o), 64'(tbl[k].ei));
      chk($sformatf("vec%0d_cnt", k), 64'(hit_cnt_o), 64'(tbl[k].ec));
    end

    // Backpressure: 0x8000 held valid for three stalled cycles.
    step(mk(0, 0, 1, 1, 1, 0, 32'h4000, 32'h8000, 0, 0, 0, 0, 0, 0));
    step(mk(1, 32'h4000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    held = mi_addr_o;
    chk("bp_first", 64'(held), 64'h8000);
    for (int k = 0; k < 3; k++) begin
      s = mk(1, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      s.r = 1'b0;
      step(s);
      chk("bp_ready_low", 64'(si_ready_o), 64'd0);
      chk("bp_hold_addr", 64'(mi_addr_o), 64'h8000);
      chk("bp_hold_valid", 64'(mi_valid_o), 64'd1);
    end
    step(mk(1, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("bp_release_addr", 64'(mi_addr_o), 64'h1234);

    // Asynchronous reset while an output is valid.
    chk("pre_rst_valid", 64'(mi_valid_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 64'(mi_valid_o), 64'd0);
    chk("async_rst_cnt", 64'(hit_cnt_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    step(mk(1, 32'h4000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("post_rst_addr", 64'(mi_addr_o), 64'h4000);
    chk("post_rst_patched", 64'(mi_patched_o), 64'd0);

    // Randomized traffic over a small address set so hits are frequent.
    for (int k = 0; k < 600; k++) begin
      logic [31:0] pick [4];
      pick[0] = 32'h4000; pick[1] = 32'h5000; pick[2] = 32'h6000;
      pick[3] = 32'h7000 + ($urandom & 32'h3);
      s = mk(($urandom_range(3) != 0), pick[$urandom_range(3)],
             ($urandom_range(7) == 0), 2'($urandom_range(3)),
             ($urandom_range(3) != 0), $urandom_range(1) == 1,
             pick[$urandom_range(3)], $urandom,
             ($urandom_range(31) == 0), 0, 0, 0, 0, 0);
      s.r = ($urandom_range(3) != 0);
      step(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addr_patch_unit.md
# addr_patch_unit

Parametrised address patch stage between the slave-side request port and the master-side request port. It holds a table of NUM_PATCH programmable match/replace entries. Each accepted address is compared against every enabled entry; on a hit the replacement address is forwarded, otherwise the original address passes through. It adds one registered pipeline stage with a valid/ready handshake, optional one-shot entries that self-disable after their first hit, and a saturating hit counter.

## Interface
Parameters:
- ADDR_W, 32, address width of lookup and replacement
- NUM_PATCH, 4, number of table entries (≥1)
- IDX_W, $clog2(NUM_PATCH) (min 1), entry index width
- CNT_W, 16, hit counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- si_valid_i  in  1  request valid
- si_ready_o  out  1  request accepted when valid&ready
- si_addr_i  in  ADDR_W  request address
- mi_valid_o  out  1  output valid
- mi_ready_i  in  1  downstream ready
- mi_addr_o  out  ADDR_W  forwarded (possibly patched) address
- mi_patched_o  out  1  1 = mi_addr_o came from a table entry
- mi_idx_o  out  IDX_W  index of the hitting entry (0 when not patched)
- ctl_we_i  in  1  table write strobe
- ctl_idx_i  in  IDX_W  entry to write
- ctl_en_i  in  1  enable bit written to entry
- ctl_oneshot_i  in  1  one-shot bit written to entry
- ctl_pat_addr_i  in  ADDR_W  match address written to entry
- ctl_pat_data_i  in  ADDR_W  replacement address written to entry
- ctl_cnt_clr_i  in  1  synchronous clear of hit_cnt_o
- hit_cnt_o  out  CNT_W  number of patched transfers accepted, saturating

## Operation
- Reset values: all entries en=0, oneshot=0, addr/data=0; mi_valid_o=0, mi_addr_o=0, mi_patched_o=0, mi_idx_o=0, hit_cnt_o=0.
- si_ready_o = !mi_valid_o | mi_ready_i (combinational; no skid buffer).
- Accept (si_valid_i & si_ready_o): compare si_addr_i for full-width equality against ctl-written match address of every entry with en=1. The lowest-index hit wins. Register mi_addr_o = winner's replacement (or si_addr_i), mi_patched_o, mi_idx_o. Set mi_valid_o=1.
- No accept and mi_ready_i=1: clear mi_valid_o. Payload registers hold their last value.
- While mi_valid_o & !mi_ready_i, all mi_* outputs hold stable.
- One-shot: on an accept that hits an entry with oneshot=1, clear that entry's en at the same clock edge. Lower-priority matching entries are unaffected.
- Table write: when ctl_we_i=1, entry ctl_idx_i takes {ctl_en_i, ctl_oneshot_i, ctl_pat_addr_i, ctl_pat_data_i} at the clock edge. ctl_idx_i ≥ NUM_PATCH is ignored.
- Write/lookup in the same cycle: the lookup uses the pre-write table contents. If a write and a one-shot clear target the same entry in the same cycle, the write wins.
- hit_cnt_o: increments by 1 per accepted hit and saturates at all-ones. If ctl_cnt_clr_i is asserted in the same cycle as a hit, the clear wins and the counter becomes 0.
- Asynchronous reset mid-transfer: the in-flight output is dropped and the table is cleared. Software must reprogram the table.

## Timing
- Latency: 1 cycle from accept to mi_valid_o.
- Throughput: 1 transfer per cycle while mi_ready_i=1.
- Table writes take effect for lookups starting the following cycle.
- No combinational path from si_addr_i to mi_*. The only combinational path is mi_ready_i→si_ready_o.

## Test plan
- Pass-through: table empty, send 0x1000, 0x2000 back-to-back with mi_ready_i=1 → mi_addr_o 0x1000 then 0x2000 on consecutive cycles, patched=0, hit_cnt_o=0.
- Persistent patch: entry 1 = {en=1, oneshot=0, 0x4000→0x8000}, send 0x4000 three times → three outputs 0x8000, idx=1, hit_cnt_o=3.
- One-shot and priority: entry 0 = oneshot 0x4000→0xA000, entry 2 = 0x4000→0xB000, send 0x4000 twice → 0xA000 (idx 0) then 0xB000 (idx 2).
- Backpressure: hold mi_ready_i=0 for 3 cycles with output 0x8000 valid → si_ready_o=0 and mi_* stable; release → next request accepted in the same cycle.
- Same-cycle write vs lookup: write entry 3 = 0x5000→0xC000 in the cycle 0x5000 is accepted → output 0x5000 unpatched; the next 0x5000 → 0xC000.
- Saturation/clear/reset: CNT_W=2, 5 hits → hit_cnt_o=3; assert clr together with a hit → 0; pulse rst_ni low while mi_valid_o=1 → mi_valid_o=0 immediately, and a later 0x4000 passes unpatched.
